// File: rtl/des_pkg.sv
// Shared DES constants and combinational primitives for the decryption core.
// Bit numbering follows the DES standard: vectors are declared [1:N], bit 1 = MSB.
package des_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRound = 2'd1,
        StDone  = 2'd2
    } state_e;

    localparam int unsigned IP_TAB [1:64] = '{
        58, 50, 42, 34, 26, 18, 10,  2,  60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6,  64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1,  59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5,  63, 55, 47, 39, 31, 23, 15,  7
    };

    localparam int unsigned FP_TAB [1:64] = '{
        40,  8, 48, 16, 56, 24, 64, 32,  39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,  37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,  35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,  33,  1, 41,  9, 49, 17, 57, 25
    };

    localparam int unsigned E_TAB [1:48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1
    };

    localparam int unsigned P_TAB [1:32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25
    };

    // Parity bits 8,16,..,64 never appear here, so they drop out of the schedule.
    localparam int unsigned PC1_TAB [1:56] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TAB [1:48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32
    };

    // Encryption-direction left-shift schedule; decryption walks it backwards.
    localparam int unsigned SHIFT [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Each row packs 16 nibbles, column 0 in the top nibble.
    localparam logic [63:0] SBOX [0:7][0:3] = '{
        '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
        '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
        '{64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
        '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
        '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
        '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
        '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
        '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
    };

    function automatic logic [1:64] ip_perm(input logic [1:64] x);
        logic [1:64] y;
        for (int j = 1; j <= 64; j++) y[j] = x[IP_TAB[j]];
        return y;
    endfunction

    function automatic logic [1:64] fp_perm(input logic [1:64] x);
        logic [1:64] y;
        for (int j = 1; j <= 64; j++) y[j] = x[FP_TAB[j]];
        return y;
    endfunction

    function automatic logic [1:56] pc1_perm(input logic [1:64] x);
        logic [1:56] y;
        for (int j = 1; j <= 56; j++) y[j] = x[PC1_TAB[j]];
        return y;
    endfunction

    function automatic logic [1:48] pc2_perm(input logic [1:56] x);
        logic [1:48] y;
        for (int j = 1; j <= 48; j++) y[j] = x[PC2_TAB[j]];
        return y;
    endfunction

    function automatic logic [1:48] e_expansion(input logic [1:32] x);
        logic [1:48] y;
        for (int j = 1; j <= 48; j++) y[j] = x[E_TAB[j]];
        return y;
    endfunction

    function automatic logic [1:32] p_permutation(input logic [1:32] x);
        logic [1:32] y;
        for (int j = 1; j <= 32; j++) y[j] = x[P_TAB[j]];
        return y;
    endfunction

    // Outer bits of each 6-bit group pick the row, inner four pick the column.
    function automatic logic [1:32] s_boxes(input logic [1:48] x);
        logic [1:32] y;
        logic [1:0]  row;
        logic [3:0]  col;
        logic [63:0] w;
        for (int b = 0; b < 8; b++) begin
            row = {x[6*b+1], x[6*b+6]};
            col = {x[6*b+2], x[6*b+3], x[6*b+4], x[6*b+5]};
            w   = SBOX[b][row] >> (4 * (15 - int'(col)));
            for (int k = 0; k < 4; k++) y[4*b+1+k] = w[3-k];
        end
        return y;
    endfunction

    function automatic logic [1:32] feistel_f(input logic [1:32] r, input logic [1:48] k);
        return p_permutation(s_boxes(e_expansion(r) ^ k));
    endfunction

endpackage

// File: rtl/des_key_schedule_rev.sv
// Reverse DES key schedule: holds C/D and emits subkeys K16..K1 one per step.
module des_key_schedule_rev
    import des_pkg::*;
#(
    parameter int unsigned STEP_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              load,
    input  logic              step,
    input  logic [STEP_W-1:0] step_idx,
    input  logic [1:64]       key,
    output logic [1:48]       subkey
);

    logic [1:56] cd_q, cd_d;

    // Undo the encryption shift for step i: rotate right by SHIFT[17-i].
    function automatic logic [1:56] cd_rotate_rev(input logic [1:56] cd, input int unsigned i);
        logic [1:28] c;
        logic [1:28] d;
        int unsigned amt;
        c   = cd[1:28];
        d   = cd[29:56];
        amt = (i >= 1 && i <= 16) ? SHIFT[17 - i] : 0;
        if (amt == 2) begin
            c = {c[27:28], c[1:26]};
            d = {d[27:28], d[1:26]};
        end else if (amt == 1) begin
            c = {c[28], c[1:27]};
            d = {d[28], d[1:27]};
        end
        return {c, d};
    endfunction

    // PC1(key) equals C16/D16 because the full schedule rotates by 28 in total.
    always_comb begin
        cd_d = cd_q;
        if (load) begin
            cd_d = pc1_perm(key);
        end else if (step) begin
            cd_d = cd_rotate_rev(cd_q, 32'(step_idx));
        end
    end

    // C/D register; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (rst_n && enable) begin
            cd_q <= cd_d;
        end
    end

    assign subkey = pc2_perm(cd_q);

endmodule

// File: rtl/des_decrypt_iterative.sv
// Iterative DES decryption core: one Feistel round per enabled clock.
module des_decrypt_iterative
    import des_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              enable,
    input  logic                              i_valid,
    output logic                              i_ready,
    input  logic [1:64]                       ciphertext,
    input  logic [1:64]                       key,
    output logic                              o_valid,
    input  logic                              o_ready,
    output logic [1:64]                       plaintext,
    output logic [$clog2(NUM_ROUNDS+1)-1:0]   round_idx
);

    localparam int unsigned RW = $clog2(NUM_ROUNDS + 1);
    localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS);

    state_e        state_q, state_d;
    logic [RW-1:0] round_q, round_d;
    logic          valid_q, valid_d;
    logic [1:64]   pt_q, pt_d;
    logic [1:32]   l_q, l_d, r_q, r_d;
    logic [1:64]   ip_ct;
    logic [1:48]   subkey;
    logic [1:32]   r_new;
    logic          ks_load, ks_step;

    des_key_schedule_rev #(
        .STEP_W (RW)
    ) u_ks (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .load     (ks_load),
        .step     (ks_step),
        .step_idx (round_q),
        .key      (key),
        .subkey   (subkey)
    );

    // Round datapath: input permutation and the Feistel mix of the current halves.
    always_comb begin
        ip_ct = ip_perm(ciphertext);
        r_new = l_q ^ feistel_f(r_q, subkey);
    end

    // FSM next-state, round counter, halves and output register.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        valid_d = valid_q;
        pt_d    = pt_q;
        l_d     = l_q;
        r_d     = r_q;
        ks_load = 1'b0;
        ks_step = 1'b0;
        case (state_q)
            StIdle: begin
                if (i_valid) begin
                    l_d     = ip_ct[1:32];
                    r_d     = ip_ct[33:64];
                    ks_load = 1'b1;
                    round_d = RW'(1);
                    state_d = StRound;
                end
            end
            StRound: begin
                ks_step = 1'b1;
                l_d     = r_q;
                r_d     = r_new;
                if (round_q == LAST_ROUND) begin
                    // Final halves are swapped before FP: {R16, L16}.
                    pt_d    = fp_perm({r_new, r_q});
                    valid_d = 1'b1;
                    round_d = '0;
                    state_d = StDone;
                end else begin
                    round_d = round_q + RW'(1);
                end
            end
            StDone: begin
                if (o_ready) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
                round_d = '0;
            end
        endcase
    end

    // Control and result registers; reset wins over the stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            round_q <= '0;
            valid_q <= 1'b0;
            pt_q    <= '0;
        end else if (enable) begin
            state_q <= state_d;
            round_q <= round_d;
            valid_q <= valid_d;
            pt_q    <= pt_d;
        end
    end

    // L/R halves; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (rst_n && enable) begin
            l_q <= l_d;
            r_q <= r_d;
        end
    end

    assign i_ready   = (state_q == StIdle);
    assign o_valid   = valid_q;
    assign plaintext = pt_q;
    assign round_idx = round_q;

endmodule

// File: tb/tb_des_decrypt_iterative.sv
// Scoreboard bench for des_decrypt_iterative: directed vectors plus round-trip traffic.
module tb_des_decrypt_iterative;
    import des_pkg::*;

    localparam logic [1:64] K1      = 64'h133457799BBCDFF1;
    localparam logic [1:64] C1      = 64'h85E813540F0AB405;
    localparam logic [1:64] P1      = 64'h0123456789ABCDEF;
    localparam logic [1:64] CT_ZERO = 64'h8CA64DE9C1B123A7;
    localparam logic [1:56] PC1_K1  = 56'hF0CCAAF556678F;
    localparam logic [1:56] CD_K1_1 = 56'hF866557AAB33C7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready = 1'b1;
    logic        i_ready;
    logic        o_valid;
    logic [1:64] ciphertext = '0;
    logic [1:64] key = '0;
    logic [1:64] plaintext;
    logic [4:0]  round_idx;

    typedef struct {
        logic [1:64] pt;
        int unsigned due;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned edge_n = 0;

    des_decrypt_iterative #(
        .NUM_ROUNDS (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .i_valid    (i_valid),
        .i_ready    (i_ready),
        .ciphertext (ciphertext),
        .key        (key),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .plaintext  (plaintext),
        .round_idx  (round_idx)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        edge_n++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: actual timeout required event", name);
    endtask

    // Textbook DES encryption with the forward (left-rotate) key schedule.
    function automatic logic [1:64] ref_encrypt(input logic [1:64] k, input logic [1:64] p);
        logic [1:56] cd;
        logic [1:28] c, d;
        logic [1:48] ks [1:16];
        logic [1:64] x, y;
        logic [1:32] l, r, t, sb, f;
        logic [1:48] er;
        logic [63:0] w;
        int          row, col;
        for (int j = 1; j <= 56; j++) cd[j] = k[PC1_TAB[j]];
        c = cd[1:28];
        d = cd[29:56];
        for (int n = 1; n <= 16; n++) begin
            for (int s = 0; s < int'(SHIFT[n]); s++) begin
                c = {c[2:28], c[1]};
                d = {d[2:28], d[1]};
            end
            cd = {c, d};
            for (int j = 1; j <= 48; j++) ks[n][j] = cd[PC2_TAB[j]];
        end
        for (int j = 1; j <= 64; j++) x[j] = p[IP_TAB[j]];
        l = x[1:32];
        r = x[33:64];
        for (int n = 1; n <= 16; n++) begin
            for (int j = 1; j <= 48; j++) er[j] = r[E_TAB[j]];
            er = er ^ ks[n];
            for (int b = 0; b < 8; b++) begin
                row = 2 * int'(er[6*b+1]) + int'(er[6*b+6]);
                col = 8 * int'(er[6*b+2]) + 4 * int'(er[6*b+3])
                    + 2 * int'(er[6*b+4]) + int'(er[6*b+5]);
                w = SBOX[b][row] >> (4 * (15 - col));
                for (int q = 0; q < 4; q++) sb[4*b+1+q] = w[3-q];
            end
            for (int j = 1; j <= 32; j++) f[j] = sb[P_TAB[j]];
            t = r;
            r = l ^ f;
            l = t;
        end
        x = {r, l};
        for (int j = 1; j <= 64; j++) y[j] = x[FP_TAB[j]];
        return y;
    endfunction

    // Expects to be called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [1:64] k, input logic [1:64] ct, input logic [1:64] exp_pt,
                        input int unsigned lat, input bit push, output int unsigned acc);
        bit   ok;
        exp_t e;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (i_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) timeout_fail("wait_i_ready");
        key        = k;
        ciphertext = ct;
        i_valid    = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        acc     = edge_n;
        if (push) begin
            e.pt  = exp_pt;
            e.due = acc + lat;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (exp_q.size() == 0 && i_ready && !o_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) timeout_fail(name);
    endtask

    // Monitor: every new output pops the oldest expectation.
    initial begin
        bit   seen;
        exp_t e;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (o_valid && !seen) begin
                seen = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: actual %h required no output", plaintext);
                end else begin
                    e = exp_q.pop_front();
                    check("plaintext", plaintext, e.pt);
                    check("latency_edge", 64'(edge_n), 64'(e.due));
                end
            end
            if (!o_valid) seen = 1'b0;
        end
    end

    initial begin
        int unsigned acc;
        logic [1:64] rk, rp, rc;
        exp_t        e;

        repeat (3) @(negedge clk);
        check("rst_i_ready", i_ready, 1);
        check("rst_o_valid", o_valid, 0);
        check("rst_round_idx", round_idx, 0);
        check("rst_plaintext", plaintext, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Known-answer block with round and key-schedule tracking.
        send(K1, C1, P1, 16, 1'b1, acc);
        for (int i = 1; i <= 16; i++) begin
            check($sformatf("round_idx_step%0d", i), round_idx, 64'(i));
            if (i == 1) check("cd_after_load", dut.u_ks.cd_q, PC1_K1);
            if (i == 2) check("cd_after_t1", dut.u_ks.cd_q, CD_K1_1);
            @(negedge clk);
        end
        check("round_idx_done", round_idx, 0);
        check("cd_after_t16", dut.u_ks.cd_q, PC1_K1);
        check("o_valid_t16", o_valid, 1);
        wait_idle("idle_kat1");

        // All-zero key.
        send('0, CT_ZERO, '0, 16, 1'b1, acc);
        repeat (16) @(negedge clk);
        check("cd_key0_t16", dut.u_ks.cd_q, 0);
        wait_idle("idle_kat0");

        // Backpressure with an ignored request, then back-to-back accept.
        o_ready = 1'b0;
        send(K1, C1, P1, 16, 1'b1, acc);
        repeat (16) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_o_valid_%0d", i), o_valid, 1);
            check($sformatf("bp_plaintext_%0d", i), plaintext, P1);
            check($sformatf("bp_i_ready_%0d", i), i_ready, 0);
            if (i == 3) begin
                key        = '0;
                ciphertext = CT_ZERO;
                i_valid    = 1'b1;
            end
            if (i == 6) i_valid = 1'b0;
            @(negedge clk);
        end
        o_ready    = 1'b1;
        key        = '0;
        ciphertext = CT_ZERO;
        i_valid    = 1'b1;
        @(negedge clk);
        check("hs_o_valid", o_valid, 0);
        check("hs_i_ready", i_ready, 1);
        e.pt  = '0;
        e.due = edge_n + 17;
        exp_q.push_back(e);
        @(negedge clk);
        i_valid = 1'b0;
        check("hs_accept_round_idx", round_idx, 1);
        check("hs_accept_i_ready", i_ready, 0);
        wait_idle("idle_bp");

        // Five-cycle stall at round 7.
        send(K1, C1, P1, 21, 1'b1, acc);
        repeat (6) @(negedge clk);
        check("stall_pre_round", round_idx, 7);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall_round_idx_%0d", i), round_idx, 7);
            check($sformatf("stall_o_valid_%0d", i), o_valid, 0);
        end
        enable = 1'b1;
        @(negedge clk);
        check("stall_resume_round", round_idx, 8);
        wait_idle("idle_stall");

        // Reset at round 9, asserted with enable low; then a fresh block.
        send(K1, C1, P1, 16, 1'b0, acc);
        repeat (8) @(negedge clk);
        check("abort_pre_round", round_idx, 9);
        rst_n  = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        check("abort_i_ready", i_ready, 1);
        check("abort_o_valid", o_valid, 0);
        check("abort_round_idx", round_idx, 0);
        check("abort_plaintext", plaintext, 0);
        rst_n  = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        send(K1, C1, P1, 16, 1'b1, acc);
        wait_idle("idle_after_abort");

        // Round trip against the reference encryptor.
        for (int n = 0; n < 1000; n++) begin
            rk = {$urandom, $urandom};
            rp = {$urandom, $urandom};
            rc = ref_encrypt(rk, rp);
            send(rk, rc, rp, 16, 1'b1, acc);
        end
        wait_idle("idle_random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
